// File: rtl/modbus_tx_frame_ctrl.sv
// rtl/modbus_tx_frame_ctrl.sv - Modbus RTU response frame sequencer into the UART byte transmitter.
// Optional MODBUS_TX_CRC_EN appends CRC-16/MODBUS (low byte, then high byte) after the data bytes.
module modbus_tx_frame_ctrl #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int GAP_BITS  = 35,
    parameter int TMO_BITS  = 12
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       frame_start,
    input  logic [7:0] frame_len,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err,
    output logic       buf_rd_en,
    output logic [7:0] buf_rd_addr,
    input  logic [7:0] buf_rd_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done
);

    localparam int          BPS     = CLK_FREQ / BAUD_RATE;
    localparam logic [23:0] GAP_CYC = 24'(GAP_BITS * BPS);
    localparam logic [23:0] TMO_CYC = 24'(TMO_BITS * BPS);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_SEND, S_CRC_LO, S_CRC_HI, S_GAP, S_ERR
    } state_t;

    state_t      state;
    logic [7:0]  len_q;
    logic [8:0]  idx;
    logic [23:0] wd_cnt;
    logic [23:0] gap_cnt;
    logic        aborted;
`ifdef MODBUS_TX_CRC_EN
    logic [15:0] crc;
    logic [3:0]  crc_cnt;
`endif

    logic [8:0] idx_next;
    logic       last_byte;
    logic       wd_expired;

    assign idx_next   = idx + 9'd1;
    assign last_byte  = (idx_next == {1'b0, len_q});
    assign wd_expired = (wd_cnt == TMO_CYC - 24'd1);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= S_IDLE;
            len_q       <= 8'd0;
            idx         <= 9'd0;
            wd_cnt      <= 24'd0;
            gap_cnt     <= 24'd0;
            aborted     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            buf_rd_en   <= 1'b0;
            buf_rd_addr <= 8'd0;
            tx_start    <= 1'b0;
            tx_data     <= 8'd0;
`ifdef MODBUS_TX_CRC_EN
            crc         <= 16'hFFFF;
            crc_cnt     <= 4'd0;
`endif
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            buf_rd_en  <= 1'b0;
            tx_start   <= 1'b0;
`ifdef MODBUS_TX_CRC_EN
            // Bit-serial CRC: one shift per cycle, finished well before the byte leaves the wire.
            if (crc_cnt != 4'd0) begin
                crc     <= crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
                crc_cnt <= crc_cnt - 4'd1;
            end
`endif
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    // busy is still high in the cycle after frame_done, so a request there is dropped
                    if (frame_start && (frame_len != 8'd0) && !busy) begin
                        len_q       <= frame_len;
                        idx         <= 9'd0;
                        aborted     <= 1'b0;
                        busy        <= 1'b1;
                        buf_rd_en   <= 1'b1;
                        buf_rd_addr <= 8'd0;
`ifdef MODBUS_TX_CRC_EN
                        crc         <= 16'hFFFF;
                        crc_cnt     <= 4'd0;
`endif
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    tx_data  <= buf_rd_data;
                    tx_start <= 1'b1;
                    wd_cnt   <= 24'd0;
`ifdef MODBUS_TX_CRC_EN
                    crc      <= crc ^ {8'h00, buf_rd_data};
                    crc_cnt  <= 4'd8;
`endif
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_done) begin
                        idx <= idx_next;
                        if (last_byte) begin
`ifdef MODBUS_TX_CRC_EN
                            tx_data  <= crc[7:0];
                            tx_start <= 1'b1;
                            wd_cnt   <= 24'd0;
                            state    <= S_CRC_LO;
`else
                            gap_cnt  <= 24'd0;
                            state    <= S_GAP;
`endif
                        end else begin
                            buf_rd_en   <= 1'b1;
                            buf_rd_addr <= idx_next[7:0];
                            state       <= S_FETCH;
                        end
                    end else if (wd_expired) begin
                        frame_err <= 1'b1;
                        aborted   <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        wd_cnt <= wd_cnt + 24'd1;
                    end
                end
                S_CRC_LO: begin
`ifdef MODBUS_TX_CRC_EN
                    if (tx_done) begin
                        tx_data  <= crc[15:8];
                        tx_start <= 1'b1;
                        wd_cnt   <= 24'd0;
                        state    <= S_CRC_HI;
                    end else if (wd_expired) begin
                        frame_err <= 1'b1;
                        aborted   <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        wd_cnt <= wd_cnt + 24'd1;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_CRC_HI: begin
`ifdef MODBUS_TX_CRC_EN
                    if (tx_done) begin
                        gap_cnt <= 24'd0;
                        state   <= S_GAP;
                    end else if (wd_expired) begin
                        frame_err <= 1'b1;
                        aborted   <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        wd_cnt <= wd_cnt + 24'd1;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_ERR: begin
                    gap_cnt <= 24'd0;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    // An aborted frame still owes the line a full silent gap, but reports no done.
                    if (gap_cnt == GAP_CYC - 24'd1) begin
                        frame_done <= !aborted;
                        state      <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 24'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
